// File: rtl/bypass_select_sequencer_if.sv
// Bundle between the register-read stages and the bypass select sequencer.
// The master drives the register-read operand/destination information.
// The slave, the sequencer, returns per-operand bypass selects.
interface bypass_select_sequencer_if #(
   parameter int LANES  = 4,
   parameter int SRCS   = 2,
   parameter int PREG_W = 7,
   parameter int LANE_W = 2
);
   logic                           stall;
   logic                           flush;
   logic [LANES*SRCS*PREG_W-1:0]   rr_src_num;
   logic [LANES*SRCS-1:0]          rr_src_read;
   logic [LANES*PREG_W-1:0]        rr_dst_num;
   logic [LANES-1:0]               rr_dst_write;
   logic [LANES*SRCS-1:0]          sel_valid;
   logic [LANES*SRCS*2-1:0]        sel_stage;
   logic [LANES*SRCS*LANE_W-1:0]   sel_lane;

   modport master (
      output stall, flush, rr_src_num, rr_src_read, rr_dst_num, rr_dst_write,
      input  sel_valid, sel_stage, sel_lane
   );

   modport slave (
      input  stall, flush, rr_src_num, rr_src_read, rr_dst_num, rr_dst_write,
      output sel_valid, sel_stage, sel_lane
   );
endinterface

// File: rtl/bypass_select_sequencer.sv
// bypass_select_sequencer
//
// Tracks in-flight destination registers of all issue lanes through the
// post-register-read producer stages. It compares each register-read
// source operand against them and registers the bypass selects. The
// selects are then presented to the execution stage one cycle later.
//
// Optional feature: define BYPASS_SEL_STAGE2_EN to track a third producer
// stage (S2). When it is undefined, only S0/S1 are tracked, and sel_stage
// bit 1 is always 0.
module bypass_select_sequencer #(
   parameter int LANES  = 4,
   parameter int SRCS   = 2,
   parameter int PREG_W = 7,
   parameter int LANE_W = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   bypass_select_sequencer_if.slave    bus
);

   localparam int OPS = LANES * SRCS;

   // Producer stage registers: S0 = one cycle past RR, S1 = two, S2 = three.
   logic [LANES*PREG_W-1:0]   r_s0_num;
   logic [LANES-1:0]          r_s0_wr;
   logic [LANES*PREG_W-1:0]   r_s1_num;
   logic [LANES-1:0]          r_s1_wr;
`ifdef BYPASS_SEL_STAGE2_EN
   logic [LANES*PREG_W-1:0]   r_s2_num;
   logic [LANES-1:0]          r_s2_wr;
`endif

   // Registered selects driven to the execution-stage bypass mux.
   logic [OPS-1:0]            r_sel_valid;
   logic [OPS*2-1:0]          r_sel_stage;
   logic [OPS*LANE_W-1:0]     r_sel_lane;

   // Combinational compare results for the current RR group.
   logic [OPS-1:0]            w_sel_valid;
   logic [OPS*2-1:0]          w_sel_stage;
   logic [OPS*LANE_W-1:0]     w_sel_lane;
   logic [PREG_W-1:0]         w_src;
   logic                      w_rd;
   logic                      w_found;
   logic                      w_take;

   // A producer lane matches when the operand reads and the producer writes the same register.
   function automatic logic prod_hit(
      input logic              rd,
      input logic              wr,
      input logic [PREG_W-1:0] pnum,
      input logic [PREG_W-1:0] snum
   );
      return rd & wr & (pnum == snum);
   endfunction

   // Priority compare: youngest stage first, then the lowest lane within a stage.
   always_comb begin
      w_sel_valid = '0;
      w_sel_stage = '0;
      w_sel_lane  = '0;
      w_src       = '0;
      w_rd        = 1'b0;
      w_found     = 1'b0;
      w_take      = 1'b0;
      for (int op = 0; op < OPS; op++) begin
         w_src   = bus.rr_src_num[op*PREG_W +: PREG_W];
         w_rd    = bus.rr_src_read[op];
         w_found = 1'b0;
         for (int l = 0; l < LANES; l++) begin
            w_take  = !w_found && prod_hit(w_rd, r_s0_wr[l], r_s0_num[l*PREG_W +: PREG_W], w_src);
            w_found = w_found | w_take;
            w_sel_valid[op]              = w_sel_valid[op] | w_take;
            w_sel_stage[op*2 +: 2]       = w_take ? 2'd0 : w_sel_stage[op*2 +: 2];
            w_sel_lane[op*LANE_W +: LANE_W] = w_take ? LANE_W'(l) : w_sel_lane[op*LANE_W +: LANE_W];
         end
         for (int l = 0; l < LANES; l++) begin
            w_take  = !w_found && prod_hit(w_rd, r_s1_wr[l], r_s1_num[l*PREG_W +: PREG_W], w_src);
            w_found = w_found | w_take;
            w_sel_valid[op]              = w_sel_valid[op] | w_take;
            w_sel_stage[op*2 +: 2]       = w_take ? 2'd1 : w_sel_stage[op*2 +: 2];
            w_sel_lane[op*LANE_W +: LANE_W] = w_take ? LANE_W'(l) : w_sel_lane[op*LANE_W +: LANE_W];
         end
`ifdef BYPASS_SEL_STAGE2_EN
         for (int l = 0; l < LANES; l++) begin
            w_take  = !w_found && prod_hit(w_rd, r_s2_wr[l], r_s2_num[l*PREG_W +: PREG_W], w_src);
            w_found = w_found | w_take;
            w_sel_valid[op]              = w_sel_valid[op] | w_take;
            w_sel_stage[op*2 +: 2]       = w_take ? 2'd2 : w_sel_stage[op*2 +: 2];
            w_sel_lane[op*LANE_W +: LANE_W] = w_take ? LANE_W'(l) : w_sel_lane[op*LANE_W +: LANE_W];
         end
`endif
      end
   end

   // Producer pipeline and select registers: reset/flush clear, stall holds, otherwise advance.
   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         r_s0_wr     <= '0;
         r_s1_wr     <= '0;
         r_sel_valid <= '0;
         r_sel_stage <= '0;
         r_sel_lane  <= '0;
         if (rst) begin
            r_s0_num <= '0;
            r_s1_num <= '0;
         end
`ifdef BYPASS_SEL_STAGE2_EN
         r_s2_wr <= '0;
         if (rst) begin
            r_s2_num <= '0;
         end
`endif
      end else if (!bus.stall) begin
         r_s0_num    <= bus.rr_dst_num;
         r_s0_wr     <= bus.rr_dst_write;
         r_s1_num    <= r_s0_num;
         r_s1_wr     <= r_s0_wr;
`ifdef BYPASS_SEL_STAGE2_EN
         r_s2_num    <= r_s1_num;
         r_s2_wr     <= r_s1_wr;
`endif
         r_sel_valid <= w_sel_valid;
         r_sel_stage <= w_sel_stage;
         r_sel_lane  <= w_sel_lane;
      end
   end

   assign bus.sel_valid = r_sel_valid;
   assign bus.sel_stage = r_sel_stage;
   assign bus.sel_lane  = r_sel_lane;

endmodule
